// File: rtl/player_input.sv
// Tug-of-war key conditioner: two active-low keys in, one-cycle
// L / R / tie move pulses out, gated by the game-active enable.
module player_input_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic acc
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  localparam bit ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    HELD,
    RELEASING
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic sync1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      s2    <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      s2    <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign cnt_inc = cnt + ONE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) begin
          if (ONE_SHOT) begin
            state_n = HELD;
            cnt_n   = '0;
            acc     = 1'b1;
          end else begin
            state_n = ARMING;
            cnt_n   = ONE;
          end
        end else begin
          cnt_n = '0;
        end
      end
      ARMING: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_inc == LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          acc     = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HELD: begin
        if (!s2) begin
          if (ONE_SHOT) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = RELEASING;
            cnt_n   = ONE;
          end
        end
      end
      RELEASING: begin
        // a pressed sample during release is bounce, not a new press
        if (s2) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt_inc == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    endcase
  end
endmodule

module player_input #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic tie
);
  logic acc_l, acc_r;

  player_input_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_l (
    .clk  (clk),
    .reset(reset),
    .key_n(key_l_n),
    .acc  (acc_l)
  );

  player_input_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_r (
    .clk  (clk),
    .reset(reset),
    .key_n(key_r_n),
    .acc  (acc_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      L   <= 1'b0;
      R   <= 1'b0;
      tie <= 1'b0;
    end else begin
      L   <= enable & acc_l & ~acc_r;
      R   <= enable & acc_r & ~acc_l;
      tie <= enable & acc_l & acc_r;
    end
  end
endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: directed scenarios plus random keys
// checked against a stable-level / run-length reference model.
module tb_player_input;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic enable = 1'b1;
  logic L, R, tie;

  int checks = 0;
  int failures = 0;

  bit m1[2], m2[2], stab[2];
  int run[2];
  bit eL, eR, eT;

  always #5 clk = ~clk;

  player_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .key_l_n(key_l_n), .key_r_n(key_r_n),
    .enable(enable),
    .L(L), .R(R), .tie(tie)
  );

  // Model: a key's accepted level flips after D consecutive
  // synchronized samples that disagree with it; a 0->1 flip is a press.
  task automatic model_edge();
    bit acc[2];
    bit pk[2];
    pk[0] = !key_l_n;
    pk[1] = !key_r_n;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m1[c] = 0; m2[c] = 0; stab[c] = 0; run[c] = 0;
      end
      eL = 0; eR = 0; eT = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      acc[c] = 0;
      if (m2[c] != stab[c]) begin
        run[c]++;
        if (run[c] == D) begin
          stab[c] = m2[c];
          run[c] = 0;
          acc[c] = stab[c];
        end
      end else begin
        run[c] = 0;
      end
      m2[c] = m1[c];
      m1[c] = pk[c];
    end
    eT = enable && acc[0] && acc[1];
    eL = enable && acc[0] && !acc[1];
    eR = enable && acc[1] && !acc[0];
  endtask

  task automatic cyc(input logic kl, input logic kr,
                     input logic en, input logic rst);
    key_l_n = kl;
    key_r_n = kr;
    enable = en;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 4; e++) begin
      cyc(0, 0, 1, 1);
      checks++;
      if ({L, R, tie} !== 3'b000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b%b%b exp=000", e, L, R, tie);
      end
    end
    do_reset();
  endtask

  task automatic test_press_latency();
    do_reset();
    for (int e = 0; e < 20; e++) begin
      cyc(0, 1, 1, 0);
      checks++;
      if (L !== 1'(e == 5) || R !== 1'b0 || tie !== 1'b0) begin
        failures++;
        $display("FAIL press_l edge=%0d got=%b%b%b exp=%b00",
                 e, L, R, tie, e == 5);
      end
      checks++;
      if ({L, R, tie} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL press_l_model edge=%0d got=%b%b%b exp=%b%b%b",
                 e, L, R, tie, eL, eR, eT);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 0; e < 15; e++) begin
      cyc(1, (e < 3) ? 1'b0 : 1'b1, 1, 0);
      checks++;
      if ({L, R, tie} !== 3'b000) begin
        failures++;
        $display("FAIL glitch_r edge=%0d got=%b%b%b exp=000",
                 e, L, R, tie);
      end
    end
    for (int e = 0; e < 12; e++) begin
      cyc(1, 0, 1, 0);
      checks++;
      if (R !== 1'(e == 5) || L !== 1'b0 || tie !== 1'b0) begin
        failures++;
        $display("FAIL stable_r edge=%0d got=%b%b%b exp=0%b0",
                 e, L, R, tie, e == 5);
      end
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int e = 0; e < 12; e++) begin
      cyc(0, 0, 1, 0);
      checks++;
      if (tie !== 1'(e == 5) || L !== 1'b0 || R !== 1'b0) begin
        failures++;
        $display("FAIL tie edge=%0d got=%b%b%b exp=00%b",
                 e, L, R, tie, e == 5);
      end
    end
    do_reset();
    for (int e = 0; e < 12; e++) begin
      cyc(0, (e < 1) ? 1'b1 : 1'b0, 1, 0);
      checks++;
      if (L !== 1'(e == 5) || R !== 1'(e == 6) || tie !== 1'b0) begin
        failures++;
        $display("FAIL offset edge=%0d got=%b%b%b exp=%b%b0",
                 e, L, R, tie, e == 5, e == 6);
      end
    end
  endtask

  task automatic test_release_bounce();
    int pulses = 0;
    do_reset();
    for (int e = 0; e < 20; e++) begin
      cyc((e >= 10 && e < 12) ? 1'b1 : 1'b0, 1, 1, 0);
      pulses += int'(L);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d exp=1", pulses);
    end
    for (int e = 0; e < 8; e++) begin
      cyc(1, 1, 1, 0);
      checks++;
      if (L !== 1'b0) begin
        failures++;
        $display("FAIL release_l edge=%0d got=%b exp=0", e, L);
      end
    end
    for (int e = 0; e < 10; e++) begin
      cyc(0, 1, 1, 0);
      checks++;
      if (L !== 1'(e == 5)) begin
        failures++;
        $display("FAIL repress_l edge=%0d got=%b exp=%b", e, L, e == 5);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int e = 0; e < 28; e++) begin
      cyc((e >= 20) ? 1'b1 : 1'b0, 1, (e >= 10) ? 1'b1 : 1'b0, 0);
      checks++;
      if ({L, R, tie} !== 3'b000) begin
        failures++;
        $display("FAIL enable_gate edge=%0d got=%b%b%b exp=000",
                 e, L, R, tie);
      end
    end
    for (int e = 0; e < 10; e++) begin
      cyc(0, 1, 1, 0);
      checks++;
      if (L !== 1'(e == 5)) begin
        failures++;
        $display("FAIL enable_repress edge=%0d got=%b exp=%b",
                 e, L, e == 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 0; e < 16; e++) begin
      cyc(0, 1, 1, (e == 3) ? 1'b1 : 1'b0);
      checks++;
      if (L !== 1'(e == 9) || R !== 1'b0 || tie !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid edge=%0d got=%b%b%b exp=%b00",
                 e, L, R, tie, e == 9);
      end
    end
  endtask

  task automatic test_random();
    logic kl = 1'b1, kr = 1'b1, en = 1'b1, rst;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) kl = ~kl;
      if ($urandom_range(5) == 0) kr = ~kr;
      if ($urandom_range(39) == 0) en = ~en;
      rst = ($urandom_range(299) == 0);
      cyc(kl, kr, en, rst);
      checks++;
      if ({L, R, tie} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b%b%b exp=%b%b%b",
                 i, L, R, tie, eL, eR, eT);
      end
      checks++;
      if (32'(L) + 32'(R) + 32'(tie) > 1) begin
        failures++;
        $display("FAIL onehot cyc=%0d got=%b%b%b exp=<=1 high",
                 i, L, R, tie);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_tie();
    test_release_bounce();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
